// File: rtl/imm_pkg.sv
// Shared definitions for the decode-stage immediate generator: immediate
// class codes, extension helpers and the stored-entry layout.
package imm_pkg;

    localparam logic [2:0] IMM_R  = 3'd0;
    localparam logic [2:0] IMM_I  = 3'd1;
    localparam logic [2:0] IMM_S  = 3'd2;
    localparam logic [2:0] IMM_B  = 3'd3;
    localparam logic [2:0] IMM_U  = 3'd4;
    localparam logic [2:0] IMM_J  = 3'd5;
    localparam logic [2:0] IMM_SH = 3'd6;
    localparam logic [2:0] IMM_Z  = 3'd7;

    // Widest immediate and sideband tag an entry can carry.
    localparam int IMM_MAX_W = 64;
    localparam int TAG_MAX_W = 16;

    // Immediates are assembled as a 32-bit word plus a fill bit. The fill bit
    // is what the upper half gets replicated with when XLEN is 64.
    function automatic logic [32:0] sext32(input logic [31:0] v);
        return {v[31], v};
    endfunction

    function automatic logic [32:0] zext32(input logic [31:0] v);
        return {1'b0, v};
    endfunction

    function automatic logic [63:0] widen64(input logic [32:0] fv);
        return {{32{fv[32]}}, fv[31:0]};
    endfunction

    // Entry layout at the widest legal size. The pipeline stores the same
    // {imm, tag} pair, trimmed to its own XLEN/TAG_W.
    typedef struct packed {
        logic [IMM_MAX_W-1:0] imm;
        logic [TAG_MAX_W-1:0] tag;
    } imm_entry_t;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decoder: (instruction, class) -> XLEN-bit immediate.
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     ins_i,
    input  logic [2:0]      op_i,
    output logic [XLEN-1:0] imm_o
);

    logic [32:0] fv;
    logic        unused_opcode;

    // The major opcode field never contributes to any immediate.
    assign unused_opcode = ^ins_i[6:0];

    // Assemble the low word and the fill bit for the selected class.
    always_comb begin
        fv = 33'd0;
        case (op_i)
            IMM_I:   fv = sext32({{20{ins_i[31]}}, ins_i[31:20]});
            IMM_S:   fv = sext32({{20{ins_i[31]}}, ins_i[31:25], ins_i[11:7]});
            IMM_B:   fv = sext32({{19{ins_i[31]}}, ins_i[31], ins_i[7],
                                  ins_i[30:25], ins_i[11:8], 1'b0});
            IMM_U:   fv = sext32({ins_i[31:12], 12'd0});
            IMM_J:   fv = sext32({{11{ins_i[31]}}, ins_i[31], ins_i[19:12],
                                  ins_i[20], ins_i[30:21], 1'b0});
            IMM_SH:  fv = (XLEN == 64) ? zext32({26'd0, ins_i[25:20]})
                                       : zext32({27'd0, ins_i[24:20]});
            IMM_Z:   fv = zext32({27'd0, ins_i[19:15]});
            default: fv = 33'd0;
        endcase
    end

    generate
        if (XLEN == 64) begin : g_xlen64
            assign imm_o = widen64(fv);
        end else begin : g_xlen32
            logic unused_fill;
            assign unused_fill = fv[32];
            assign imm_o       = fv[31:0];
        end
    endgenerate

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with valid/ready on both sides. A main
// register (M) drives the outputs; a skid register (K) absorbs the one entry
// that can arrive while M is stalled, so in_ready depends on state only.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_ins,
    input  logic [2:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag
);

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] tag;
    } entry_t;

    logic [XLEN-1:0] dec_imm;
    entry_t          new_e;
    entry_t          m_q, m_d;
    entry_t          k_q, k_d;
    logic            m_valid_q, m_valid_d;
    logic            k_valid_q, k_valid_d;
    logic            m_load, k_load;
    logic            accept, pop;

    // Decoding happens before storage, so M and K hold finished immediates.
    imm_decode #(.XLEN(XLEN)) u_decode (
        .ins_i (in_ins),
        .op_i  (in_op),
        .imm_o (dec_imm)
    );

    assign new_e.imm = dec_imm;
    assign new_e.tag = in_tag;

    // Ready is held low throughout reset, otherwise purely from K occupancy.
    assign in_ready  = ~k_valid_q & ~rst;
    assign accept    = in_valid & in_ready;
    assign pop       = m_valid_q & out_ready;

    assign out_valid = m_valid_q;
    assign out_imm   = m_q.imm;
    assign out_tag   = m_q.tag;

    // Skid control: refill M from K first to keep FIFO order, otherwise from
    // the input; park the input in K only when M is full and stalled.
    always_comb begin
        m_d       = m_q;
        k_d       = k_q;
        m_valid_d = m_valid_q;
        k_valid_d = k_valid_q;
        m_load    = 1'b0;
        k_load    = 1'b0;
        if (!m_valid_q || pop) begin
            if (k_valid_q) begin
                m_d       = k_q;
                m_load    = 1'b1;
                m_valid_d = 1'b1;
                k_valid_d = accept;
                if (accept) begin
                    k_d    = new_e;
                    k_load = 1'b1;
                end
            end else if (accept) begin
                m_d       = new_e;
                m_load    = 1'b1;
                m_valid_d = 1'b1;
            end else begin
                m_valid_d = 1'b0;
            end
        end else if (accept) begin
            k_d       = new_e;
            k_load    = 1'b1;
            k_valid_d = 1'b1;
        end
    end

    // State and entry registers; data words change only when loaded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid_q <= 1'b0;
            k_valid_q <= 1'b0;
            m_q       <= '0;
            k_q       <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            k_valid_q <= k_valid_d;
            if (m_load) begin
                m_q <= m_d;
            end
            if (k_load) begin
                k_q <= k_d;
            end
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench: XLEN=32 and XLEN=64 instances share the same stimulus.
module tb_imm_gen_pipe;

    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic [31:0]      in_ins = '0;
    logic [2:0]       in_op = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_ready = 1'b0;

    logic             rdy32, ov32, rdy64, ov64;
    logic [31:0]      imm32;
    logic [63:0]      imm64;
    logic [TAG_W-1:0] tag32, tag64;

    imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy32),
        .in_ins(in_ins), .in_op(in_op), .in_tag(in_tag),
        .out_valid(ov32), .out_ready(out_ready), .out_imm(imm32), .out_tag(tag32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W)) dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy64),
        .in_ins(in_ins), .in_op(in_op), .in_tag(in_tag),
        .out_valid(ov64), .out_ready(out_ready), .out_imm(imm64), .out_tag(tag64)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0]      imm;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t        q32[$];
    exp_t        q64[$];
    logic [63:0] pend32 = '0;
    logic [63:0] pend64 = '0;
    bit          acc_last = 1'b0;
    int          pops32 = 0;
    int          vectors = 0;
    int          miscompares = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // Reference immediate from the instruction-set field rules.
    function automatic logic [63:0] ref_imm(logic [31:0] ins, logic [2:0] op, bit x64);
        longint v;
        case (op)
            3'd1:    v = longint'($signed(ins[31:20]));
            3'd2:    v = longint'($signed({ins[31:25], ins[11:7]}));
            3'd3:    v = longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
            3'd4:    v = longint'($signed(ins[31:12])) * 4096;
            3'd5:    v = longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
            3'd6:    v = x64 ? longint'(ins[25:20]) : longint'(ins[24:20]);
            3'd7:    v = longint'(ins[19:15]);
            default: v = 0;
        endcase
        return x64 ? 64'(v) : {32'd0, v[31:0]};
    endfunction

    // Monitor: occupancy model predicts handshake outputs; queues hold data.
    always @(negedge clk) begin
        int   n32, n64;
        exp_t e;
        if (!rst) begin
            n32 = q32.size();
            n64 = q64.size();
            chk("in_ready32", {63'd0, rdy32}, {63'd0, n32 < 2});
            chk("in_ready64", {63'd0, rdy64}, {63'd0, n64 < 2});
            chk("out_valid32", {63'd0, ov32}, {63'd0, n32 > 0});
            chk("out_valid64", {63'd0, ov64}, {63'd0, n64 > 0});
            if (ov32 && n32 > 0) begin
                chk("imm32", {32'd0, imm32}, q32[0].imm);
                chk("tag32", {59'd0, tag32}, {59'd0, q32[0].tag});
                if (out_ready) begin
                    void'(q32.pop_front());
                    pops32++;
                end
            end
            if (ov64 && n64 > 0) begin
                chk("imm64", imm64, q64[0].imm);
                chk("tag64", {59'd0, tag64}, {59'd0, q64[0].tag});
                if (out_ready) void'(q64.pop_front());
            end
            acc_last = in_valid && (n32 < 2);
            if (acc_last) begin
                e.tag = in_tag;
                e.imm = pend32;
                q32.push_back(e);
                e.imm = pend64;
                q64.push_back(e);
            end
        end else begin
            acc_last = 1'b0;
        end
    end

    task automatic drive(bit v, logic [31:0] ins, logic [2:0] op,
                         logic [TAG_W-1:0] tag, bit ordy);
        in_valid  = v;
        in_ins    = ins;
        in_op     = op;
        in_tag    = tag;
        out_ready = ordy;
        pend32    = ref_imm(ins, op, 1'b0);
        pend64    = ref_imm(ins, op, 1'b1);
        @(posedge clk);
        #1;
    endtask

    // Present one entry with literal expectations until it is taken.
    task automatic send(logic [31:0] ins, logic [2:0] op, logic [TAG_W-1:0] tag,
                        logic [63:0] e32, logic [63:0] e64);
        bit done = 1'b0;
        in_valid = 1'b1;
        in_ins   = ins;
        in_op    = op;
        in_tag   = tag;
        pend32   = e32;
        pend64   = e64;
        for (int t = 0; t < 20 && !done; t++) begin
            @(posedge clk);
            #1;
            done = acc_last;
        end
        if (!done) chk("send_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 20 && q32.size() > 0; t++)
            drive(1'b0, 32'd0, 3'd0, '0, 1'b1);
        chk("drain_left", 64'(q32.size()), 64'd0);
    endtask

    logic [31:0] t2_ins[5] = '{32'h00112623, 32'hFE000EE3, 32'h12345037,
                               32'h000F8073, 32'h01F09093};
    logic [2:0]  t2_op[5]  = '{3'd2, 3'd3, 3'd4, 3'd7, 3'd6};
    logic [31:0] t2_exp[5] = '{32'h0000000C, 32'hFFFFFFFC, 32'h12345000,
                               32'h0000001F, 32'h0000001F};

    initial begin
        int next_tag, p0;

        // Reset state
        #2;
        chk("rst_out_valid32", {63'd0, ov32}, 64'd0);
        chk("rst_out_imm32", {32'd0, imm32}, 64'd0);
        chk("rst_out_tag32", {59'd0, tag32}, 64'd0);
        chk("rst_in_ready32", {63'd0, rdy32}, 64'd0);
        chk("rst_out_valid64", {63'd0, ov64}, 64'd0);
        chk("rst_out_imm64", imm64, 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // addi x1,x0,-1: result one cycle after acceptance
        out_ready = 1'b1;
        send(32'hFFF00093, 3'd1, 5'd1, 64'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF);
        chk("lat_out_valid", {63'd0, ov32}, 64'd1);
        chk("lat_out_imm", {32'd0, imm32}, 64'hFFFFFFFF);

        // Class table at XLEN=32; XLEN=64 side from the reference
        for (int i = 0; i < 5; i++)
            send(t2_ins[i], t2_op[i], 5'(i + 2), {32'd0, t2_exp[i]},
                 ref_imm(t2_ins[i], t2_op[i], 1'b1));

        // XLEN=64 specifics
        send(32'h80000037, 3'd4, 5'd10, 64'h80000000, 64'hFFFFFFFF_80000000);
        send(32'h03F09093, 3'd6, 5'd11, 64'h1F, 64'h3F);
        send(32'hFFFFFFFF, 3'd0, 5'd12, 64'd0, 64'd0);
        drain();

        // Back-to-back tags 1..6 with a stall window
        next_tag = 1;
        for (int c = 0; c < 40 && next_tag <= 6; c++) begin
            drive(1'b1, $urandom, 3'($urandom_range(0, 7)), 5'(next_tag),
                  !(c >= 3 && c <= 5));
            if (acc_last) next_tag++;
        end
        in_valid = 1'b0;
        chk("bp_all_sent", 64'(next_tag), 64'd7);
        drain();

        // Simultaneous accept and pop, one result per cycle
        p0 = pops32;
        for (int c = 0; c < 10; c++) begin
            chk("stream_in_ready", {63'd0, rdy32}, 64'd1);
            drive(1'b1, $urandom, 3'($urandom_range(0, 7)), 5'($urandom), 1'b1);
        end
        drive(1'b0, 32'd0, 3'd0, '0, 1'b1);
        chk("stream_pops", 64'(pops32 - p0), 64'd10);
        drain();

        // Random traffic with random backpressure
        for (int c = 0; c < 400; c++)
            drive($urandom_range(0, 3) != 0, $urandom, 3'($urandom_range(0, 7)),
                  5'($urandom), $urandom_range(0, 3) != 0);
        in_valid = 1'b0;
        drain();

        // Async reset with M and K both full
        out_ready = 1'b0;
        send(32'hFFF00093, 3'd1, 5'd20, 64'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF);
        send(32'h12345037, 3'd4, 5'd21, 64'h12345000, 64'h12345000);
        chk("full_in_ready", {63'd0, rdy32}, 64'd0);
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid32", {63'd0, ov32}, 64'd0);
        chk("arst_out_imm32", {32'd0, imm32}, 64'd0);
        chk("arst_out_tag32", {59'd0, tag32}, 64'd0);
        chk("arst_in_ready32", {63'd0, rdy32}, 64'd0);
        chk("arst_out_imm64", imm64, 64'd0);
        q32.delete();
        q64.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        send(32'h00112623, 3'd2, 5'd22, 64'h0C, 64'h0C);
        chk("post_rst_valid", {63'd0, ov32}, 64'd1);
        chk("post_rst_imm", {32'd0, imm32}, 64'h0C);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
